// File: rtl/pc_sequencer_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pc_sequencer_pkg : shared types and defaults for the fetch PC sequencer
// Revision 1.0
// ----------------------------------------------------------------------------
package pc_sequencer_pkg;

    localparam int PC_W_DEF     = 8;
    localparam int RESET_PC_DEF = 0;

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        HALTED = 1'b1
    } pc_state_t;

    typedef enum logic [2:0] {
        SRC_SEQ  = 3'd0,
        SRC_BR   = 3'd1,
        SRC_JMP  = 3'd2,
        SRC_RET  = 3'd3,
        SRC_HOLD = 3'd4
    } pc_src_t;

endpackage
`default_nettype wire

// File: rtl/return_addr_stack.sv
`default_nettype none
// ----------------------------------------------------------------------------
// return_addr_stack : circular return-address stack, oldest entry overwritten
// when full. Revision 1.0
// ----------------------------------------------------------------------------
module return_addr_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] top,
    output logic         empty,
    output logic         full,
    output logic         err_pulse
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wp;
    logic [CNT_W-1:0] r_cnt;
    logic [PTR_W-1:0] w_top_idx;

    // r_wp is the next write slot, so the most recent entry sits just below it
    assign w_top_idx = r_wp - PTR_W'(1);
    assign top       = r_mem[w_top_idx];
    assign empty     = (r_cnt == '0);
    assign full      = (r_cnt == CNT_W'(DEPTH));
    assign err_pulse = (push & full) | (pop & ~push & empty);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp  <= '0;
            r_cnt <= '0;
        end else if (push) begin
            r_wp <= r_wp + PTR_W'(1);
            if (!full) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end else if (pop && !empty) begin
            r_wp  <= w_top_idx;
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wp] <= din;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pc_sequencer : fetch PC selection, pipeline flush, halt/resume and RAS
// Revision 1.0
// ----------------------------------------------------------------------------
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int              PC_W      = PC_W_DEF,
    parameter int              RAS_DEPTH = 4,
    parameter logic [PC_W-1:0] RESET_PC  = PC_W'(RESET_PC_DEF)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            br_taken,
    input  logic [PC_W-1:0] br_target,
    input  logic            jmp_valid,
    input  logic [PC_W-1:0] jmp_target,
    input  logic            call,
    input  logic            ret_valid,
    input  logic [PC_W-1:0] id_pc_plus1,
    input  logic            halt_req,
    input  logic            resume,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_plus1,
    output logic            flush_if,
    output logic            flush_id,
    output logic            halted,
    output logic            ras_empty,
    output logic            ras_err
);

    pc_state_t       r_state;
    pc_state_t       w_state_nxt;
    pc_src_t         w_src;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_nxt;
    logic [PC_W-1:0] w_pc_plus1;
    logic [PC_W-1:0] w_ras_top;
    logic            r_flush_if;
    logic            r_flush_id;
    logic            r_ras_err;
    logic            w_flush_if_nxt;
    logic            w_flush_id_nxt;
    logic            w_push;
    logic            w_pop;
    logic            w_ras_empty;
    logic            w_ras_full_unused;
    logic            w_ras_err_pulse;

    assign w_pc_plus1 = r_pc + PC_W'(1);

    return_addr_stack #(
        .DEPTH (RAS_DEPTH),
        .W     (PC_W)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .pop       (w_pop),
        .din       (id_pc_plus1),
        .top       (w_ras_top),
        .empty     (w_ras_empty),
        .full      (w_ras_full_unused),
        .err_pulse (w_ras_err_pulse)
    );

    always_comb begin
        w_src          = SRC_HOLD;
        w_state_nxt    = r_state;
        w_push         = 1'b0;
        w_pop          = 1'b0;
        w_flush_if_nxt = 1'b0;
        w_flush_id_nxt = 1'b0;
        case (r_state)
            RUN: begin
                if (br_taken) begin
                    w_src = SRC_BR;
                end else if (jmp_valid && !stall) begin
                    w_src  = SRC_JMP;
                    w_push = call;
                end else if (ret_valid && !stall) begin
                    w_src = SRC_RET;
                    w_pop = 1'b1;
                end else if (!stall) begin
                    w_src = SRC_SEQ;
                end
                // The halt edge still redirects pc, but no flush is shown while halted
                if (halt_req && !br_taken) begin
                    w_state_nxt = HALTED;
                end else begin
                    w_flush_if_nxt = (w_src == SRC_BR) || (w_src == SRC_JMP) ||
                                     (w_src == SRC_RET);
                    w_flush_id_nxt = (w_src == SRC_BR);
                end
            end
            HALTED: begin
                if (resume && !halt_req) begin
                    w_state_nxt = RUN;
                end
            end
            default: begin
                w_state_nxt = RUN;
            end
        endcase
    end

    always_comb begin
        w_pc_nxt = r_pc;
        case (w_src)
            SRC_SEQ:  w_pc_nxt = w_pc_plus1;
            SRC_BR:   w_pc_nxt = br_target;
            SRC_JMP:  w_pc_nxt = jmp_target;
            SRC_RET:  w_pc_nxt = w_ras_empty ? RESET_PC : w_ras_top;
            SRC_HOLD: w_pc_nxt = r_pc;
            default:  w_pc_nxt = r_pc;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= RUN;
            r_pc       <= RESET_PC;
            r_flush_if <= 1'b0;
            r_flush_id <= 1'b0;
            r_ras_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_flush_if <= w_flush_if_nxt;
            r_flush_id <= w_flush_id_nxt;
            r_ras_err  <= r_ras_err | w_ras_err_pulse;
        end
    end

    assign pc        = r_pc;
    assign pc_plus1  = w_pc_plus1;
    assign flush_if  = r_flush_if;
    assign flush_id  = r_flush_id;
    assign halted    = (r_state == HALTED);
    assign ras_empty = w_ras_empty;
    assign ras_err   = r_ras_err;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_pc_sequencer : scoreboard bench for pc_sequencer (PC_W=8, RAS_DEPTH=4)
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_pc_sequencer;

    logic       clk;
    logic       rst_n;
    logic       stall;
    logic       br_taken;
    logic [7:0] br_target;
    logic       jmp_valid;
    logic [7:0] jmp_target;
    logic       call;
    logic       ret_valid;
    logic [7:0] id_pc_plus1;
    logic       halt_req;
    logic       resume;
    logic [7:0] pc;
    logic [7:0] pc_plus1;
    logic       flush_if;
    logic       flush_id;
    logic       halted;
    logic       ras_empty;
    logic       ras_err;

    typedef struct packed {
        logic [7:0] pc;
        logic       fif;
        logic       fid;
        logic       hlt;
        logic       emp;
        logic       err;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic exp_err  = 1'b0;

    pc_sequencer #(
        .PC_W      (8),
        .RAS_DEPTH (4),
        .RESET_PC  (8'h00)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .jmp_valid   (jmp_valid),
        .jmp_target  (jmp_target),
        .call        (call),
        .ret_valid   (ret_valid),
        .id_pc_plus1 (id_pc_plus1),
        .halt_req    (halt_req),
        .resume      (resume),
        .pc          (pc),
        .pc_plus1    (pc_plus1),
        .flush_if    (flush_if),
        .flush_id    (flush_id),
        .halted      (halted),
        .ras_empty   (ras_empty),
        .ras_err     (ras_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic idle();
        stall       = 1'b0;
        br_taken    = 1'b0;
        br_target   = 8'h00;
        jmp_valid   = 1'b0;
        jmp_target  = 8'h00;
        call        = 1'b0;
        ret_valid   = 1'b0;
        id_pc_plus1 = 8'h00;
        halt_req    = 1'b0;
        resume      = 1'b0;
    endtask

    // Expectation is queued with the stimulus, then retired after the edge
    task automatic cyc(input logic [7:0] e_pc, input logic e_fif, input logic e_fid,
                       input logic e_hlt, input logic e_emp);
        exp_t e;
        exp_t got;
        logic [7:0] e_pp1;
        e.pc  = e_pc;
        e.fif = e_fif;
        e.fid = e_fid;
        e.hlt = e_hlt;
        e.emp = e_emp;
        e.err = exp_err;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got   = sb_q.pop_front();
        e_pp1 = got.pc + 8'h01;
        check_eq("pc",        {24'h0, pc},        {24'h0, got.pc});
        check_eq("pc_plus1",  {24'h0, pc_plus1},  {24'h0, e_pp1});
        check_eq("flush_if",  {31'h0, flush_if},  {31'h0, got.fif});
        check_eq("flush_id",  {31'h0, flush_id},  {31'h0, got.fid});
        check_eq("halted",    {31'h0, halted},    {31'h0, got.hlt});
        check_eq("ras_empty", {31'h0, ras_empty}, {31'h0, got.emp});
        check_eq("ras_err",   {31'h0, ras_err},   {31'h0, got.err});
        idle();
    endtask

    task automatic check_reset_state();
        check_eq("rst_pc",       {24'h0, pc},        32'h0);
        check_eq("rst_flush_if", {31'h0, flush_if},  32'h0);
        check_eq("rst_flush_id", {31'h0, flush_id},  32'h0);
        check_eq("rst_halted",   {31'h0, halted},    32'h0);
        check_eq("rst_empty",    {31'h0, ras_empty}, 32'h1);
        check_eq("rst_err",      {31'h0, ras_err},   32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rst_n = 1'b0;
        #3;
        check_reset_state();
        #5;
        rst_n = 1'b1;

        // free run from reset up to pc=0x10
        for (int i = 1; i <= 16; i++) begin
            cyc(8'(i), 1'b0, 1'b0, 1'b0, 1'b1);
        end

        // taken branch overrides stall
        br_taken = 1'b1; br_target = 8'h2A; stall = 1'b1;
        cyc(8'h2A, 1'b1, 1'b1, 1'b0, 1'b1);
        cyc(8'h2B, 1'b0, 1'b0, 1'b0, 1'b1);

        // call then return
        jmp_valid = 1'b1; call = 1'b1; jmp_target = 8'h40; id_pc_plus1 = 8'h12;
        cyc(8'h40, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(8'h41, 1'b0, 1'b0, 1'b0, 1'b0);
        ret_valid = 1'b1;
        cyc(8'h12, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc(8'h13, 1'b0, 1'b0, 1'b0, 1'b1);

        // overflow: fifth call overwrites the oldest entry
        for (int i = 1; i <= 5; i++) begin
            jmp_valid = 1'b1; call = 1'b1;
            jmp_target = 8'h50 + 8'(i); id_pc_plus1 = 8'(i);
            if (i == 5) exp_err = 1'b1;
            cyc(8'h50 + 8'(i), 1'b1, 1'b0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            ret_valid = 1'b1;
            cyc(8'(5 - i), 1'b1, 1'b0, 1'b0, (i == 3));
        end
        // underflow returns to RESET_PC
        ret_valid = 1'b1;
        cyc(8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc(8'h01, 1'b0, 1'b0, 1'b0, 1'b1);

        // halt / resume
        jmp_valid = 1'b1; jmp_target = 8'h20;
        cyc(8'h20, 1'b1, 1'b0, 1'b0, 1'b1);
        halt_req = 1'b1;
        cyc(8'h21, 1'b0, 1'b0, 1'b1, 1'b1);
        cyc(8'h21, 1'b0, 1'b0, 1'b1, 1'b1);
        br_taken = 1'b1; br_target = 8'h77; jmp_valid = 1'b1; jmp_target = 8'h66; call = 1'b1;
        cyc(8'h21, 1'b0, 1'b0, 1'b1, 1'b1);
        resume = 1'b1;
        cyc(8'h21, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(8'h22, 1'b0, 1'b0, 1'b0, 1'b1);
        halt_req = 1'b1;
        cyc(8'h23, 1'b0, 1'b0, 1'b1, 1'b1);
        halt_req = 1'b1; resume = 1'b1;
        cyc(8'h23, 1'b0, 1'b0, 1'b1, 1'b1);
        resume = 1'b1;
        cyc(8'h23, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(8'h24, 1'b0, 1'b0, 1'b0, 1'b1);

        // stall holds pc and blocks a jump
        stall = 1'b1;
        cyc(8'h24, 1'b0, 1'b0, 1'b0, 1'b1);
        stall = 1'b1; jmp_valid = 1'b1; jmp_target = 8'h90;
        cyc(8'h24, 1'b0, 1'b0, 1'b0, 1'b1);

        // wrap-around
        jmp_valid = 1'b1; jmp_target = 8'hFF;
        cyc(8'hFF, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

        // branch beats simultaneous call and return; RAS untouched
        jmp_valid = 1'b1; call = 1'b1; jmp_target = 8'h30; id_pc_plus1 = 8'h99;
        cyc(8'h30, 1'b1, 1'b0, 1'b0, 1'b0);
        br_taken = 1'b1; br_target = 8'h60;
        jmp_valid = 1'b1; call = 1'b1; jmp_target = 8'h70; id_pc_plus1 = 8'hAB;
        ret_valid = 1'b1;
        cyc(8'h60, 1'b1, 1'b1, 1'b0, 1'b0);
        ret_valid = 1'b1;
        cyc(8'h99, 1'b1, 1'b0, 1'b0, 1'b1);

        // asynchronous reset mid-stream
        jmp_valid = 1'b1; call = 1'b1; jmp_target = 8'h44; id_pc_plus1 = 8'h55;
        cyc(8'h44, 1'b1, 1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state();
        exp_err = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc(8'h01, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(8'h02, 1'b0, 1'b0, 1'b0, 1'b1);

        check_eq("sb_drained", sb_q.size(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
